issue_controller: RTL and testbench

// - In-order instruction issue stage between global instruction inputs and the decoder/pipeline.
// - Buffers incoming instructions in a small queue and tracks in-flight register writes in a scoreboard.
// - Stalls any instruction whose register source is still being written (RAW hazard).
// - The bench no longer waits fixed cycles between dependent LD/OUT pairs.

---
 rtl/issue_controller_pkg.sv | 20 ++
 rtl/issue_scoreboard.sv | 27 ++
 rtl/issue_controller.sv | 83 ++++++++
 tb/tb_issue_controller.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/issue_controller_pkg.sv
// issue_controller_pkg: shared processor types for the issue stage.
package issue_controller_pkg;

    typedef enum logic [2:0] {LD, OUT, ADD, SUB, NOP} opc_t;

    typedef enum logic [2:0] {R0 = 3'd0, R1 = 3'd1, R2 = 3'd2, R3 = 3'd3, IMM = 3'd4} src_t;

    typedef struct packed {
        opc_t       opcode;
        logic [7:0] imm;
        src_t       src1;
        src_t       src2;
        src_t       dst;
    } instr_t;

    function automatic logic writes_dst(opc_t op);
        return op inside {LD, ADD, SUB};
    endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// issue_scoreboard: per-register countdown of cycles until an issued write lands.
module issue_scoreboard #(
    parameter int NUM_REGS   = 4,
    parameter int PIPE_DEPTH = 3
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        set_en,
    input  logic [$clog2(NUM_REGS)-1:0] set_reg,
    output logic [NUM_REGS-1:0]         busy
);
    localparam int RW = $clog2(NUM_REGS);
    localparam int CW = $clog2(PIPE_DEPTH + 1);

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
        logic [CW-1:0] sb;
        // a fresh write outranks the countdown of an older one
        always_ff @(posedge clock or negedge reset)
            if (!reset)
                sb <= '0;
            else
                sb <= (set_en && set_reg == RW'(r)) ? CW'(PIPE_DEPTH) :
                      (sb != '0) ? sb - CW'(1) : sb;
        assign busy[r] = sb != '0;
    end

endmodule

// File: rtl/issue_controller.sv
// issue_controller: in-order issue queue that holds back instructions with RAW hazards.
module issue_controller
    import issue_controller_pkg::*;
#(
    parameter int NUM_REGS    = 4,
    parameter int PIPE_DEPTH  = 3,
    parameter int QUEUE_DEPTH = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             instv,
    output logic             in_ready,
    input  opc_t             opcode,
    input  logic [7:0]       imm,
    input  src_t             src1,
    input  src_t             src2,
    input  src_t             dst,
    input  logic             flush,
    input  logic             issue_ready,
    output logic             issue_valid,
    output opc_t             issue_opcode,
    output logic [7:0]       issue_imm,
    output src_t             issue_src1,
    output src_t             issue_src2,
    output src_t             issue_dst,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] issued_count
);
    localparam int RW = $clog2(NUM_REGS);
    localparam int PW = QUEUE_DEPTH > 1 ? $clog2(QUEUE_DEPTH) : 1;
    localparam int OW = $clog2(QUEUE_DEPTH + 1);

    instr_t              q [QUEUE_DEPTH];
    logic [PW-1:0]       rd_ptr, wr_ptr;
    logic [OW-1:0]       occ;
    instr_t              head;
    logic [NUM_REGS-1:0] busy;
    logic                present, hazard, push, pop, set_en;

    assign present     = occ != '0;
    assign head        = present ? q[rd_ptr] : '0;
    assign hazard      = present && ((head.src1 < IMM && busy[head.src1[RW-1:0]]) ||
                                     (head.src2 < IMM && busy[head.src2[RW-1:0]]));
    assign issue_valid = present && !hazard && !flush;
    assign in_ready    = occ < OW'(QUEUE_DEPTH) && !flush;
    assign push        = instv && in_ready;
    assign pop         = issue_valid && issue_ready;
    assign set_en      = pop && writes_dst(head.opcode) && head.dst < IMM;

    assign issue_opcode = head.opcode;
    assign issue_imm    = head.imm;
    assign issue_src1   = head.src1;
    assign issue_src2   = head.src2;
    assign issue_dst    = head.dst;

    always_ff @(posedge clock)
        if (push) q[wr_ptr] <= '{opcode, imm, src1, src2, dst};

    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            occ          <= '0;
            stall_count  <= '0;
            issued_count <= '0;
        end else begin
            rd_ptr <= flush ? '0 : !pop ? rd_ptr : rd_ptr == PW'(QUEUE_DEPTH - 1) ? '0 : rd_ptr + PW'(1);
            wr_ptr <= flush ? '0 : !push ? wr_ptr : wr_ptr == PW'(QUEUE_DEPTH - 1) ? '0 : wr_ptr + PW'(1);
            occ    <= flush ? '0 : occ + OW'(push) - OW'(pop);
            if (hazard && !flush && ~&stall_count) stall_count <= stall_count + CNT_W'(1);
            if (pop && ~&issued_count) issued_count <= issued_count + CNT_W'(1);
        end

    issue_scoreboard #(.NUM_REGS(NUM_REGS), .PIPE_DEPTH(PIPE_DEPTH)) u_sb (
        .clock  (clock),
        .reset  (reset),
        .set_en (set_en),
        .set_reg(head.dst[RW-1:0]),
        .busy   (busy)
    );

endmodule

// File: tb/tb_issue_controller.sv
// tb_issue_controller: directed and random checks of the issue stage against a cycle-time model.
module tb_issue_controller;
    import issue_controller_pkg::*;

    localparam int QD = 2;
    localparam int PD = 3;

    logic        clock = 0, reset, instv, flush, issue_ready;
    opc_t        opcode, issue_opcode;
    logic [7:0]  imm, issue_imm;
    src_t        src1, src2, dst, issue_src1, issue_src2, issue_dst;
    logic        in_ready, issue_valid;
    logic [15:0] stall_count, issued_count;

    issue_controller dut (
        .clock(clock), .reset(reset), .instv(instv), .in_ready(in_ready),
        .opcode(opcode), .imm(imm), .src1(src1), .src2(src2), .dst(dst),
        .flush(flush), .issue_ready(issue_ready), .issue_valid(issue_valid),
        .issue_opcode(issue_opcode), .issue_imm(issue_imm), .issue_src1(issue_src1),
        .issue_src2(issue_src2), .issue_dst(issue_dst),
        .stall_count(stall_count), .issued_count(issued_count)
    );

    always #5 clock = ~clock;

    int n_chk = 0, n_fail = 0;
    // model: register n may be read from cycle busy_until[n] onward
    instr_t mq[$];
    int     busy_until[4];
    int     t = 0, m_stall = 0, m_issued = 0;
    bit     last_push;
    int     fire_t[$];
    opc_t   fire_opc[$];
    int     fire_imm[$];
    int     s0, i0, t_ld;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit m_blocked(src_t s);
        return s < IMM && t < busy_until[int'(s)];
    endfunction

    task automatic mreset();
        mq.delete();
        foreach (busy_until[i]) busy_until[i] = 0;
        m_stall = 0;
        m_issued = 0;
    endtask

    task automatic chk_reset();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_valid", issue_valid, 0);
        chk("rst_fields", 32'({issue_opcode, issue_imm, issue_src1, issue_src2, issue_dst}), 0);
        chk("rst_stall", stall_count, 0);
        chk("rst_issued", issued_count, 0);
    endtask

    task automatic tick();
        instr_t h, cur;
        bit pres, haz, v, rdy, pop;
        @(negedge clock);
        cur  = '{opcode, imm, src1, src2, dst};
        pres = mq.size() > 0;
        h    = pres ? mq[0] : '0;
        haz  = pres && (m_blocked(h.src1) || m_blocked(h.src2));
        v    = pres && !haz && !flush;
        rdy  = mq.size() < QD && !flush;
        chk("issue_valid", issue_valid, v);
        chk("in_ready", in_ready, rdy);
        chk("fields", 32'({issue_opcode, issue_imm, issue_src1, issue_src2, issue_dst}), 32'(h));
        chk("stall_count", stall_count, m_stall);
        chk("issued_count", issued_count, m_issued);
        if (issue_valid && issue_ready) begin
            fire_t.push_back(t);
            fire_opc.push_back(issue_opcode);
            fire_imm.push_back(int'(issue_imm));
        end
        last_push = instv && in_ready;
        pop = v && issue_ready;
        @(posedge clock);
        if (haz && !flush && m_stall < 65535) m_stall++;
        if (pop) begin
            if (h.opcode inside {LD, ADD, SUB} && h.dst < IMM) busy_until[int'(h.dst)] = t + PD + 1;
            if (m_issued < 65535) m_issued++;
            void'(mq.pop_front());
        end
        if (flush) mq.delete();
        else if (instv && rdy) mq.push_back(cur);
        t++;
        #1;
    endtask

    task automatic offer(opc_t o, logic [7:0] i, src_t a, src_t b, src_t d);
        instv = 1; opcode = o; imm = i; src1 = a; src2 = b; dst = d;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (last_push) break;
        end
        chk("accept", last_push, 1);
        instv = 0;
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic clear_log();
        fire_t.delete(); fire_opc.delete(); fire_imm.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 0; instv = 0; flush = 0; issue_ready = 0;
        opcode = NOP; imm = 0; src1 = IMM; src2 = IMM; dst = R0;
        mreset();
        #1 chk_reset();
        #1 reset = 1;
        idle(2);

        // RAW stall: OUT R3 waits for LD R3
        issue_ready = 1;
        clear_log();
        s0 = int'(stall_count);
        offer(LD, 8'd5, IMM, IMM, R3);
        offer(OUT, 8'd0, R3, IMM, R0);
        idle(8);
        chk("raw_fires", fire_t.size(), 2);
        chk("raw_gap", fire_t[1] - fire_t[0], 4);
        chk("raw_out_opc", fire_opc[1], OUT);
        chk("raw_stalls", int'(stall_count) - s0, 3);

        // independent LDs issue back-to-back; OUT waits only on R3
        clear_log();
        s0 = int'(stall_count);
        offer(LD, 8'd5, IMM, IMM, R3);
        offer(LD, 8'd43, IMM, IMM, R2);
        offer(OUT, 8'd0, R3, IMM, R0);
        idle(8);
        chk("ind_fires", fire_t.size(), 3);
        chk("ind_ld_gap", fire_t[1] - fire_t[0], 1);
        chk("ind_out_gap", fire_t[2] - fire_t[0], 4);
        chk("ind_stalls", int'(stall_count) - s0, 2);

        // full queue holds the third offer until a pop
        issue_ready = 0;
        clear_log();
        offer(OUT, 8'd11, IMM, IMM, R0);
        offer(OUT, 8'd22, IMM, IMM, R0);
        instv = 1; imm = 8'd33;
        chk("full_in_ready", in_ready, 0);
        idle(2);
        chk("full_held", last_push, 0);
        issue_ready = 1;
        offer(OUT, 8'd33, IMM, IMM, R0);
        idle(4);
        chk("full_fires", fire_imm.size(), 3);
        chk("full_ord0", fire_imm[0], 11);
        chk("full_ord1", fire_imm[1], 22);
        chk("full_ord2", fire_imm[2], 33);

        // backpressure on a hazard-free head
        issue_ready = 0;
        offer(OUT, 8'd77, IMM, IMM, R0);
        s0 = int'(stall_count);
        i0 = int'(issued_count);
        idle(5);
        chk("bp_valid", issue_valid, 1);
        chk("bp_imm", issue_imm, 77);
        chk("bp_stall", stall_count, s0);
        chk("bp_issued", issued_count, i0);
        issue_ready = 1;
        idle(2);

        // flush drops the queued OUT; scoreboard keeps tracking LD R1
        clear_log();
        offer(LD, 8'd9, IMM, IMM, R1);
        offer(OUT, 8'd44, R1, IMM, R0);
        flush = 1;
        tick();
        flush = 0;
        offer(OUT, 8'd55, IMM, R1, R0);
        idle(8);
        chk("fl_fires", fire_t.size(), 2);
        chk("fl_out_imm", fire_imm[1], 55);
        chk("fl_out_gap", fire_t[1] - fire_t[0], 4);

        // random traffic
        for (int k = 0; k < 300; k++) begin
            instv = 1'($urandom_range(0, 1));
            opcode = opc_t'($urandom_range(0, 4));
            imm = 8'($urandom);
            src1 = src_t'($urandom_range(0, 4));
            src2 = src_t'($urandom_range(0, 4));
            dst = src_t'($urandom_range(0, 4));
            issue_ready = $urandom_range(0, 3) != 0;
            flush = $urandom_range(0, 19) == 0;
            tick();
        end
        instv = 0; flush = 0; issue_ready = 1;
        idle(6);

        // asynchronous reset with two entries queued
        issue_ready = 0;
        offer(OUT, 8'd1, IMM, IMM, R0);
        offer(ADD, 8'd2, IMM, IMM, R1);
        chk("pre_rst_valid", issue_valid, 1);
        reset = 0;
        #1 mreset();
        chk_reset();
        #2 reset = 1;
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
